eu_merge: RTL and testbench

- Execution unit of the simple processor.
- Merges the math (ADD/ADDI/SUB), gate (AND/OR/XOR/NOT) and shift (SLL/SLLI/SLR/SLRI) sub-units behind a single func_t decode.
- Produces one registered DATAWIDTH-bit result per cycle for the writeback stage.

---
 rtl/eu_merge.sv | 176 +++++++++++++++++
 tb/tb_eu_merge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/eu_merge.sv
// Execution unit: merges math, gate and shift sub-units behind one func_t decode, 1-cycle registered result.
// Optional zero/carry flag outputs are built when EU_MERGE_FLAGS_EN is defined.
package simple_processor_pkg;
  localparam int DATAWIDTH = 32;

  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_ADDI = 4'd1,
    FUNC_SUB  = 4'd2,
    FUNC_AND  = 4'd3,
    FUNC_OR   = 4'd4,
    FUNC_XOR  = 4'd5,
    FUNC_NOT  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;
endpackage

module eu_merge
  import simple_processor_pkg::*;
#(
  parameter int DATAWIDTH = simple_processor_pkg::DATAWIDTH,
  parameter int IMMWIDTH  = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATAWIDTH-1:0] rs1_data_i,
  input  logic [DATAWIDTH-1:0] rs2_data_i,
  input  logic [IMMWIDTH-1:0]  imm_i,
  input  func_t                func_i,
  output logic [DATAWIDTH-1:0] result,
  output logic                 invalid_o
`ifdef EU_MERGE_FLAGS_EN
  ,
  output logic                 zero_o,
  output logic                 carry_o
`endif
);

  typedef enum logic [1:0] {
    GATE_AND = 2'd0,
    GATE_OR  = 2'd1,
    GATE_XOR = 2'd2,
    GATE_NOT = 2'd3
  } gate_sel_t;

  logic [DATAWIDTH-1:0] imm_ext;
  logic                 math_en;
  logic                 gate_en;
  logic                 shift_en;
  logic                 invalid_d;
  logic [DATAWIDTH-1:0] add_b;
  logic                 add_cin;
  gate_sel_t            gate_sel;
  logic                 s_r;
  logic [DATAWIDTH-1:0] shift_amt;

  logic [DATAWIDTH-1:0] math_sum;
  logic [DATAWIDTH-1:0] math_out;
  logic [DATAWIDTH-1:0] gate_out;
  logic [DATAWIDTH-1:0] shift_out;
  logic [DATAWIDTH-1:0] result_d;
  logic [DATAWIDTH-1:0] result_q;
  logic                 invalid_q;

  assign imm_ext = {{(DATAWIDTH-IMMWIDTH){imm_i[IMMWIDTH-1]}}, imm_i};

  // Unknown or unlisted encodings fall to default, leaving every sub-unit disabled.
  always_comb begin
    math_en   = 1'b0;
    gate_en   = 1'b0;
    shift_en  = 1'b0;
    invalid_d = 1'b0;
    add_b     = rs2_data_i;
    add_cin   = 1'b0;
    gate_sel  = GATE_AND;
    s_r       = 1'b0;
    shift_amt = rs2_data_i;
    case (func_i)
      FUNC_ADD:  math_en = 1'b1;
      FUNC_ADDI: begin math_en = 1'b1; add_b = imm_ext; end
      FUNC_SUB:  begin math_en = 1'b1; add_b = ~rs2_data_i; add_cin = 1'b1; end
      FUNC_AND:  begin gate_en = 1'b1; gate_sel = GATE_AND; end
      FUNC_OR:   begin gate_en = 1'b1; gate_sel = GATE_OR; end
      FUNC_XOR:  begin gate_en = 1'b1; gate_sel = GATE_XOR; end
      FUNC_NOT:  begin gate_en = 1'b1; gate_sel = GATE_NOT; end
      FUNC_SLL:  shift_en = 1'b1;
      FUNC_SLLI: begin shift_en = 1'b1; shift_amt = imm_ext; end
      FUNC_SLR:  begin shift_en = 1'b1; s_r = 1'b1; end
      FUNC_SLRI: begin shift_en = 1'b1; s_r = 1'b1; shift_amt = imm_ext; end
      default:   invalid_d = 1'b1;
    endcase
  end

`ifdef EU_MERGE_FLAGS_EN
  logic math_cout;
  always_comb begin
    {math_cout, math_sum} = {1'b0, rs1_data_i} + {1'b0, add_b}
                          + {{DATAWIDTH{1'b0}}, add_cin};
  end
`else
  always_comb begin
    math_sum = rs1_data_i + add_b + {{(DATAWIDTH-1){1'b0}}, add_cin};
  end
`endif

  always_comb begin
    math_out = math_en ? math_sum : '0;
  end

  always_comb begin
    gate_out = '0;
    if (gate_en) begin
      case (gate_sel)
        GATE_AND: gate_out = rs1_data_i & rs2_data_i;
        GATE_OR:  gate_out = rs1_data_i | rs2_data_i;
        GATE_XOR: gate_out = rs1_data_i ^ rs2_data_i;
        default:  gate_out = ~rs1_data_i;
      endcase
    end
  end

  // Full-width shift amount: anything >= DATAWIDTH (incl. negative immediates) yields zero.
  always_comb begin
    shift_out = '0;
    if (shift_en) begin
      shift_out = s_r ? (rs1_data_i >> shift_amt) : (rs1_data_i << shift_amt);
    end
  end

  always_comb begin
    result_d = math_out | gate_out | shift_out;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      invalid_q <= invalid_d;
    end
  end

  assign result    = result_q;
  assign invalid_o = invalid_q;

`ifdef EU_MERGE_FLAGS_EN
  logic zero_d;
  logic zero_q;
  logic carry_d;
  logic carry_q;

  // For SUB the adder carry-out is the inverted borrow, i.e. rs1 >= rs2 unsigned.
  always_comb begin
    zero_d  = (result_d == '0);
    carry_d = math_en & math_cout;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_o  = zero_q;
  assign carry_o = carry_q;
`endif

endmodule

// File: tb/tb_eu_merge.sv
// Self-checking bench for eu_merge: directed vectors, reset behaviour, and a randomized back-to-back run.
module tb_eu_merge;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [5:0]  imm_i;
  func_t       func_i;
  logic [31:0] result;
  logic        invalid_o;
`ifdef EU_MERGE_FLAGS_EN
  logic        zero_o;
  logic        carry_o;
`endif

  int pass_count  = 0;
  int check_count = 0;

  eu_merge dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .imm_i      (imm_i),
    .func_i     (func_i),
    .result     (result),
    .invalid_o  (invalid_o)
`ifdef EU_MERGE_FLAGS_EN
    ,
    .zero_o     (zero_o),
    .carry_o    (carry_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drive on the falling edge, then look at outputs 1 time unit after the next rising edge.
  task automatic applyStimulus(input func_t f, input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] imm);
    @(negedge clk_i);
    func_i     = f;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = imm;
    @(posedge clk_i);
    #1;
  endtask

  // Independent reference: subtraction and shifts written directly rather than as adder tricks.
  function automatic void refModel(input func_t f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] imm, output logic [31:0] res,
                                   output logic inv);
    logic [31:0] ie;
    ie  = {{26{imm[5]}}, imm};
    res = 32'h0;
    inv = 1'b0;
    case (f)
      FUNC_ADD:  res = a + b;
      FUNC_ADDI: res = a + ie;
      FUNC_SUB:  res = a - b;
      FUNC_AND:  res = a & b;
      FUNC_OR:   res = a | b;
      FUNC_XOR:  res = a ^ b;
      FUNC_NOT:  res = ~a;
      FUNC_SLL:  res = (b > 32'd31)  ? 32'h0 : (a << b[4:0]);
      FUNC_SLLI: res = (ie > 32'd31) ? 32'h0 : (a << ie[4:0]);
      FUNC_SLR:  res = (b > 32'd31)  ? 32'h0 : (a >> b[4:0]);
      FUNC_SLRI: res = (ie > 32'd31) ? 32'h0 : (a >> ie[4:0]);
      default:   inv = 1'b1;
    endcase
  endfunction

  initial begin
    logic [31:0] exp_res;
    logic        exp_inv;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  ri;
    func_t       rf;

    $display("[TB] starting eu_merge bench");
    rst_i = 1'b1;
    applyStimulus(FUNC_ADD, 32'd5, 32'd7, 6'h00);
    applyStimulus(FUNC_ADD, 32'd5, 32'd7, 6'h00);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_invalid", {31'h0, invalid_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("first_add", result, 32'h0000000C);

    applyStimulus(FUNC_ADDI, 32'h00000010, 32'h0, 6'h3F);
    checkOutput("addi_neg1", result, 32'h0000000F);
    applyStimulus(FUNC_SUB, 32'h5, 32'h7, 6'h00);
    checkOutput("sub_5_7", result, 32'hFFFFFFFE);
    applyStimulus(FUNC_ADD, 32'hFFFFFFFF, 32'h1, 6'h00);
    checkOutput("add_wrap", result, 32'h00000000);
`ifdef EU_MERGE_FLAGS_EN
    checkOutput("add_wrap_zero", {31'h0, zero_o}, 32'h1);
    checkOutput("add_wrap_carry", {31'h0, carry_o}, 32'h1);
    applyStimulus(FUNC_SUB, 32'd3, 32'd5, 6'h00);
    checkOutput("sub_3_5_carry", {31'h0, carry_o}, 32'h0);
    checkOutput("sub_3_5_zero", {31'h0, zero_o}, 32'h0);
    applyStimulus(FUNC_SUB, 32'd5, 32'd3, 6'h00);
    checkOutput("sub_5_3_carry", {31'h0, carry_o}, 32'h1);
    applyStimulus(FUNC_OR, 32'hFFFFFFFF, 32'h1, 6'h00);
    checkOutput("or_carry", {31'h0, carry_o}, 32'h0);
`endif

    applyStimulus(FUNC_AND, 32'hF0F0F0F0, 32'hFF00FF00, 6'h00);
    checkOutput("and", result, 32'hF000F000);
    applyStimulus(FUNC_OR, 32'hF0F0F0F0, 32'hFF00FF00, 6'h00);
    checkOutput("or", result, 32'hFFF0FFF0);
    applyStimulus(FUNC_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 6'h00);
    checkOutput("xor", result, 32'h0FF00FF0);
    applyStimulus(FUNC_NOT, 32'h0, 32'h12345678, 6'h00);
    checkOutput("not", result, 32'hFFFFFFFF);

    applyStimulus(FUNC_SLL, 32'h1, 32'd31, 6'h00);
    checkOutput("sll_31", result, 32'h80000000);
    applyStimulus(FUNC_SLR, 32'h80000000, 32'd32, 6'h00);
    checkOutput("slr_32", result, 32'h0);
    applyStimulus(FUNC_SLR, 32'h80000000, 32'd31, 6'h00);
    checkOutput("slr_31", result, 32'h1);
    applyStimulus(FUNC_SLL, 32'h1, 32'h00000100, 6'h00);
    checkOutput("sll_256", result, 32'h0);
    applyStimulus(FUNC_SLLI, 32'h3, 32'h0, 6'h04);
    checkOutput("slli_4", result, 32'h30);
    applyStimulus(FUNC_SLRI, 32'hFFFFFFFF, 32'h0, 6'h20);
    checkOutput("slri_neg", result, 32'h0);
    applyStimulus(FUNC_SLRI, 32'h00000F00, 32'h0, 6'h08);
    checkOutput("slri_8", result, 32'h0000000F);

    applyStimulus(func_t'(4'd11), 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h3F);
    checkOutput("illegal_result", result, 32'h0);
    checkOutput("illegal_invalid", {31'h0, invalid_o}, 32'h1);
    applyStimulus(FUNC_ADD, 32'd1, 32'd2, 6'h00);
    checkOutput("after_illegal_result", result, 32'h3);
    checkOutput("after_illegal_invalid", {31'h0, invalid_o}, 32'h0);

    // Mid-stream reset must discard the operation sampled with it and clear invalid_o.
    applyStimulus(func_t'(4'd15), 32'h0, 32'h0, 6'h00);
    rst_i = 1'b1;
    applyStimulus(FUNC_ADD, 32'd100, 32'd1, 6'h00);
    checkOutput("midreset_result", result, 32'h0);
    checkOutput("midreset_invalid", {31'h0, invalid_o}, 32'h0);
    rst_i = 1'b0;
    applyStimulus(FUNC_ADD, 32'd100, 32'd1, 6'h00);
    checkOutput("post_midreset", result, 32'd101);

    exp_res = 32'h0;
    exp_inv = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        checkOutput("rand_result", result, exp_res);
        checkOutput("rand_invalid", {31'h0, invalid_o}, {31'h0, exp_inv});
      end
      rf = func_t'(4'($urandom_range(0, 15)));
      r1 = $urandom;
      r2 = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      ri = 6'($urandom_range(0, 63));
      func_i     = rf;
      rs1_data_i = r1;
      rs2_data_i = r2;
      imm_i      = ri;
      refModel(rf, r1, r2, ri, exp_res, exp_inv);
    end
    @(negedge clk_i);
    checkOutput("rand_last_result", result, exp_res);
    checkOutput("rand_last_invalid", {31'h0, invalid_o}, {31'h0, exp_inv});

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
